multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-003 SHALL have port start, input, 1, a level that begins program execution from IDLE.
REQ-004 SHALL have port op_code, input, 3, the opcode from instruction memory at address pc.
REQ-005 SHALL have port mem_ready, input, 1, the RAM access-complete indication.
REQ-006 SHALL have port pc, output, 8, the instruction-memory address.
REQ-007 SHALL have port imem_rd, output, 1, the instruction-fetch strobe.
REQ-008 SHALL have ports wEnable_BR (1), SEL_dmx (1), OP_alu (4), W_ram (1) and R_ram (1), all outputs, forming the datapath control word.
REQ-009 SHALL have ports busy (1), halted (1), illegal (1) and mem_err (1), all outputs, as status.

Function
REQ-010 SHALL implement the states IDLE, FETCH, DECODE, EXEC, WB, MEM and HALT, all registered.
REQ-011 SHALL define the idle control word as wEnable_BR=0, SEL_dmx=1, OP_alu=1111, W_ram=0 and R_ram=0, and drive it in every state or cycle not listed otherwise.
REQ-012 SHALL behave in IDLE as follows: busy=0; start=1 -> FETCH; start is ignored in all other states.
REQ-013 SHALL behave in FETCH as follows: imem_rd=1 for exactly one cycle; the internal ir captures op_code at the end of the cycle; -> DECODE.
REQ-014 SHALL decode ir in DECODE as follows: 000/001/010 -> EXEC; 011/100 -> MEM; 111 -> HALT (illegal=0); 101/110 -> HALT with illegal set.
REQ-015 SHALL drive in EXEC: SEL_dmx=0; OP_alu=0010 for 000, 0110 for 001 and 0111 for 010; W_ram=R_ram=0; -> WB.
REQ-016 SHALL behave in WB as follows: wEnable_BR=1 for exactly one cycle; SEL_dmx and OP_alu held at their EXEC values; pc increments; -> FETCH.
REQ-017 SHALL drive in MEM: SEL_dmx=1; for 011, OP_alu=0010 and W_ram=1; for 100, OP_alu=1111 and R_ram=1; wEnable_BR=0.
REQ-018 SHALL hold the MEM control word constant until mem_ready=1 is sampled in MEM; then pc increments and the state goes to FETCH; mem_ready outside MEM is ignored.
REQ-019 SHALL behave in HALT as follows: halted=1 and the idle control word is driven; only rst_n leaves HALT.
REQ-020 SHALL assert busy in every state except IDLE and HALT.
REQ-021 SHALL make pc an 8-bit unsigned counter that wraps from 255 to 0 without a flag.
REQ-022 SHALL complete an ALU instruction in 4 cycles (FETCH, DECODE, EXEC, WB) and a memory instruction in 3+N cycles, where N is the number of MEM cycles with mem_ready=0.
REQ-023 SHALL never assert W_ram and R_ram in the same cycle, and never assert wEnable_BR together with W_ram or R_ram.
REQ-024 SHALL keep illegal and mem_err sticky until reset.

Reset
REQ-025 SHALL, when rst_n=0 at a rising edge, put the block in IDLE with pc=0, ir=000, the wait counter at 0, busy=0, halted=0, illegal=0, mem_err=0, imem_rd=0 and the idle control word.
REQ-026 SHALL obey REQ-025 for a reset in any state, including mid-MEM with W_ram=1 (W_ram=0 in the following cycle).
REQ-027 SHALL give rst_n priority over start and mem_ready in the same cycle.

Configuration
REQ-028 SHALL, with MEM_TIMEOUT_EN defined, use a 4-bit counter that counts MEM cycles with mem_ready=0; at the 16th such cycle it sets mem_err, deasserts W_ram/R_ram and goes to HALT without incrementing pc.
REQ-029 SHALL, with MEM_TIMEOUT_EN defined, clear the counter on every MEM entry; mem_ready=1 in the 16th cycle wins over the timeout.
REQ-030 SHALL, with MEM_TIMEOUT_EN undefined, omit the counter, tie mem_err to 0 and wait in MEM indefinitely.

Verification
REQ-031 SHALL be verified by this scenario: reset, start=1, op_code=001 -> imem_rd high in cycle 1, OP_alu=0110/SEL_dmx=0 in cycles 3-4, wEnable_BR=1 only in cycle 4, pc 0->1 after cycle 4.
REQ-032 SHALL be verified by this scenario: op_code=011 with mem_ready low for 3 cycles then high -> W_ram=1 and OP_alu=0010 for 4 MEM cycles, wEnable_BR=0 throughout, pc increments once.
REQ-033 SHALL be verified by this scenario: op_code=110 -> HALT after DECODE, illegal=1, halted=1, busy=0; start pulses ignored; rst_n low for one edge returns IDLE and pc=0.
REQ-034 SHALL be verified by this scenario: preload pc to 255 via 255 op_code=000 instructions, then one more -> pc=0 and execution continues.
REQ-035 SHALL be verified by this scenario: with MEM_TIMEOUT_EN, op_code=100 and mem_ready held low -> R_ram=1 for 16 cycles, then mem_err=1, halted=1, pc unchanged; without the macro, R_ram stays high for 100 cycles and mem_err=0.
REQ-036 SHALL be verified by this scenario: rst_n asserted in the second MEM cycle of a store -> the next cycle shows the idle control word, W_ram=0, IDLE.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle control unit: sequences FETCH/DECODE/EXEC/WB/MEM per instruction and drives the datapath control word.
// Latency: ALU instruction 4 cycles, memory instruction 3+N cycles (N = MEM cycles spent waiting on mem_ready).
// Backpressure: mem_ready stalls the unit in MEM; with MEM_TIMEOUT_EN defined a 16-cycle stall aborts to HALT with mem_err.
//
// Ports:
//   clk, rst_n (synchronous, active-low)  - clock and reset
//   start                                 - level, leaves IDLE into FETCH
//   op_code[2:0]                          - instruction at address pc, captured at the end of FETCH
//   mem_ready                             - RAM access complete, only looked at in MEM
//   pc[7:0], imem_rd                      - instruction-memory address and fetch strobe
//   wEnable_BR, SEL_dmx, OP_alu[3:0],
//   W_ram, R_ram                          - datapath control word
//   busy, halted, illegal, mem_err        - status (illegal and mem_err are sticky until reset)
//
// Optional feature: define MEM_TIMEOUT_EN to enable the MEM stall timeout.

module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] op_code,
    input  logic       mem_ready,
    output logic [7:0] pc,
    output logic       imem_rd,
    output logic       wEnable_BR,
    output logic       SEL_dmx,
    output logic [3:0] OP_alu,
    output logic       W_ram,
    output logic       R_ram,
    output logic       busy,
    output logic       halted,
    output logic       illegal,
    output logic       mem_err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] WB     = 3'd4;
    localparam logic [2:0] MEM    = 3'd5;
    localparam logic [2:0] HALT   = 3'd6;

    // Opcodes
    localparam logic [2:0] OPC_ADD  = 3'b000;
    localparam logic [2:0] OPC_SUB  = 3'b001;
    localparam logic [2:0] OPC_SLT  = 3'b010;
    localparam logic [2:0] OPC_ST   = 3'b011;
    localparam logic [2:0] OPC_LD   = 3'b100;
    localparam logic [2:0] OPC_HALT = 3'b111;

    // ALU function codes
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOP  = 4'b1111;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [2:0] ir;
    logic       pc_inc;
    logic       set_illegal;
    logic [3:0] alu_sel;

`ifdef MEM_TIMEOUT_EN
    // Counts MEM cycles with mem_ready low; the 16th such cycle aborts.
    logic [3:0] wait_cnt;
    logic       timeout;

    assign timeout = (state == MEM) && !mem_ready && (wait_cnt == 4'hF);
`endif

    // ALU function for the instruction in ir; only meaningful for the ALU opcodes.
    always_comb begin
        alu_sel = ALU_NOP;
        case (ir)
            OPC_ADD: alu_sel = ALU_ADD;
            OPC_SUB: alu_sel = ALU_SUB;
            OPC_SLT: alu_sel = ALU_SLT;
            default: alu_sel = ALU_NOP;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_nxt   = state;
        pc_inc      = 1'b0;
        set_illegal = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                state_nxt = DECODE;
            end
            DECODE: begin
                case (ir)
                    OPC_ADD, OPC_SUB, OPC_SLT: state_nxt = EXEC;
                    OPC_ST, OPC_LD:            state_nxt = MEM;
                    OPC_HALT:                  state_nxt = HALT;
                    default: begin
                        state_nxt   = HALT;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            EXEC: begin
                state_nxt = WB;
            end
            WB: begin
                state_nxt = FETCH;
                pc_inc    = 1'b1;
            end
            MEM: begin
                // mem_ready in the 16th waiting cycle takes precedence over the timeout.
                if (mem_ready) begin
                    state_nxt = FETCH;
                    pc_inc    = 1'b1;
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeout) begin
                    state_nxt = HALT;
                end
`endif
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, program counter, instruction register, sticky illegal flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= 8'd0;
            ir      <= 3'b000;
            illegal <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == FETCH) begin
                ir <= op_code;
            end
            // Plain 8-bit add: wraps 255 -> 0 silently.
            if (pc_inc) begin
                pc <= pc + 8'd1;
            end
            if (set_illegal) begin
                illegal <= 1'b1;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= 4'd0;
            mem_err  <= 1'b0;
        end else begin
            // Cleared on the way into MEM so every access gets a fresh budget.
            if (state == DECODE) begin
                wait_cnt <= 4'd0;
            end else if ((state == MEM) && !mem_ready) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            if (timeout) begin
                mem_err <= 1'b1;
            end
        end
    end
`else
    assign mem_err = 1'b0;
`endif

    // Control word: decoded from the registered state and ir only (Moore),
    // so a reset edge returns the idle word on the very next cycle.
    always_comb begin
        imem_rd    = 1'b0;
        wEnable_BR = 1'b0;
        SEL_dmx    = 1'b1;
        OP_alu     = ALU_NOP;
        W_ram      = 1'b0;
        R_ram      = 1'b0;
        case (state)
            FETCH: begin
                imem_rd = 1'b1;
            end
            EXEC: begin
                SEL_dmx = 1'b0;
                OP_alu  = alu_sel;
            end
            WB: begin
                // Mux select and ALU function held from EXEC while the register file writes.
                wEnable_BR = 1'b1;
                SEL_dmx    = 1'b0;
                OP_alu     = alu_sel;
            end
            MEM: begin
                SEL_dmx = 1'b1;
                if (ir == OPC_ST) begin
                    OP_alu = ALU_ADD;
                    W_ram  = 1'b1;
                end else begin
                    OP_alu = ALU_NOP;
                    R_ram  = 1'b1;
                end
            end
            default: begin
                imem_rd = 1'b0;
            end
        endcase
    end

    assign busy   = (state != IDLE) && (state != HALT);
    assign halted = (state == HALT);

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] op_code;
    logic       mem_ready;
    logic [7:0] pc;
    logic       imem_rd;
    logic       wEnable_BR;
    logic       SEL_dmx;
    logic [3:0] OP_alu;
    logic       W_ram;
    logic       R_ram;
    logic       busy;
    logic       halted;
    logic       illegal;
    logic       mem_err;

    int checks = 0;
    int errors = 0;

    // Reference model state: architectural pc and sticky flags.
    logic [7:0] m_pc  = 8'd0;
    logic       m_ill = 1'b0;
    logic       m_err = 1'b0;

    logic [20:0] obs;

    multicycle_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op_code    (op_code),
        .mem_ready  (mem_ready),
        .pc         (pc),
        .imem_rd    (imem_rd),
        .wEnable_BR (wEnable_BR),
        .SEL_dmx    (SEL_dmx),
        .OP_alu     (OP_alu),
        .W_ram      (W_ram),
        .R_ram      (R_ram),
        .busy       (busy),
        .halted     (halted),
        .illegal    (illegal),
        .mem_err    (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {imem_rd, wEnable_BR, SEL_dmx, OP_alu, W_ram, R_ram,
                  busy, halted, illegal, mem_err, pc};

    // Expected observation for one cycle; status flags and pc come from the model.
    function automatic logic [20:0] cw(input logic ir, input logic we, input logic sel,
                                       input logic [3:0] op, input logic w, input logic r,
                                       input logic bsy, input logic hlt);
        return {ir, we, sel, op, w, r, bsy, hlt, m_ill, m_err, m_pc};
    endfunction

    function automatic logic [3:0] alu_code(input logic [2:0] opc);
        case (opc)
            3'd0:    return 4'b0010;
            3'd1:    return 4'b0110;
            3'd2:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [20:0] mem_cw(input logic [2:0] opc);
        return cw(1'b0, 1'b0, 1'b1, (opc == 3'd3) ? 4'b0010 : 4'b1111,
                  opc == 3'd3, opc == 3'd4, 1'b1, 1'b0);
    endfunction

    task automatic chk(input string tag, input logic [20:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        // Control-word exclusivity must hold in every sampled cycle.
        checks++;
        assert (!(W_ram && R_ram) && !(wEnable_BR && (W_ram || R_ram))) else begin
            errors++;
            $error("FAIL %s_exclusive observed W=%b R=%b WE=%b expected no overlap",
                   tag, W_ram, R_ram, wEnable_BR);
        end
    endtask

    // Called at a negedge; reset is applied with start and mem_ready high to test its priority.
    task automatic do_reset();
        rst_n     = 1'b0;
        start     = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        m_pc  = 8'd0;
        m_ill = 1'b0;
        m_err = 1'b0;
        chk("reset", cw(1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0));
        rst_n = 1'b1;
        start = 1'b0;
    endtask

    task automatic idle_then_start();
        @(negedge clk);
        chk("idle", cw(1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0));
        start = 1'b1;
    endtask

    task automatic fetch_decode(input logic [2:0] opc);
        op_code = opc;
        @(negedge clk);
        chk("fetch", cw(1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0));
        mem_ready = 1'($urandom);
        @(negedge clk);
        chk("decode", cw(1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0));
        mem_ready = 1'($urandom);
    endtask

    // One complete instruction; nwait = MEM cycles with mem_ready low before completion.
    task automatic run_instr(input logic [2:0] opc, input int nwait);
        logic [3:0] aop;
        fetch_decode(opc);
        if (opc <= 3'd2) begin
            aop = alu_code(opc);
            @(negedge clk);
            chk("exec", cw(1'b0, 1'b0, 1'b0, aop, 1'b0, 1'b0, 1'b1, 1'b0));
            mem_ready = 1'($urandom);
            @(negedge clk);
            chk("wb", cw(1'b0, 1'b1, 1'b0, aop, 1'b0, 1'b0, 1'b1, 1'b0));
            mem_ready = 1'($urandom);
            m_pc = m_pc + 8'd1;
        end else if (opc <= 3'd4) begin
            for (int i = 0; i <= nwait; i++) begin
                @(negedge clk);
                chk((opc == 3'd3) ? "store" : "load", mem_cw(opc));
                mem_ready = (i == nwait);
            end
            m_pc = m_pc + 8'd1;
        end else begin
            m_ill = m_ill | (opc != 3'd7);
            @(negedge clk);
            chk("halt", cw(1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1));
        end
    endtask

    // FETCH, DECODE, then n MEM cycles with mem_ready held low.
    task automatic run_stall(input logic [2:0] opc, input int n);
        fetch_decode(opc);
        mem_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("stall", mem_cw(opc));
            mem_ready = 1'b0;
        end
    endtask

    task automatic hold_halt(input int n);
        for (int i = 0; i < n; i++) begin
            start     = ~start;
            mem_ready = 1'($urandom);
            @(negedge clk);
            chk("halt_hold", cw(1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1));
        end
    endtask

    initial begin
        logic [2:0] ropc;
        rst_n     = 1'b0;
        start     = 1'b0;
        op_code   = 3'd0;
        mem_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // Single SUB: cycles 1-4, pc 0 -> 1
        idle_then_start();
        run_instr(3'd1, 0);
        // Store with three wait cycles
        run_instr(3'd3, 3);

        // Random mix of ALU and memory instructions
        for (int k = 0; k < 40; k++) begin
            ropc = 3'($urandom_range(0, 4));
            run_instr(ropc, int'($urandom_range(0, 5)));
        end

        // mem_ready arriving in the 16th waiting cycle completes the access
        run_instr(3'd3, 15);

        // Legal HALT: illegal stays 0, start ignored
        run_instr(3'd7, 0);
        hold_halt(3);
        do_reset();

        // Reset in the second MEM cycle of a store
        idle_then_start();
        run_stall(3'd3, 2);
        do_reset();

        // Illegal opcode
        idle_then_start();
        run_instr(3'd6, 0);
        hold_halt(4);
        do_reset();

        // pc wrap: 256 ALU instructions then one more at pc 0
        idle_then_start();
        for (int k = 0; k < 256; k++) begin
            run_instr(3'd0, 0);
        end
        run_instr(3'd2, 0);
        run_instr(3'd4, 1);

        // Load with mem_ready held low
`ifdef MEM_TIMEOUT_EN
        run_stall(3'd4, 16);
        m_err = 1'b1;
        @(negedge clk);
        chk("timeout_halt", cw(1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1));
        hold_halt(2);
`else
        run_stall(3'd4, 100);
`endif
        do_reset();
        idle_then_start();
        run_instr(3'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
